// File: rtl/eth_tx_arbiter_if.sv
// Byte-stream bundle between NUM_SRC frame builders, the TX arbiter and the MAC framer.
// master: frame builders plus framer side (testbench); slave: the arbiter.
interface eth_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 2
) ();
  logic [NUM_SRC-1:0]   src_valid;
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_last;
  logic                 tx_ready;

  modport master (
    output src_valid, src_data, src_last, tx_ready,
    input  src_ready, tx_valid, tx_data, tx_last
  );

  modport slave (
    input  src_valid, src_data, src_last, tx_ready,
    output src_ready, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: shares one 8-bit Ethernet TX byte stream between NUM_SRC frame sources.
// Whole frames are granted, an inter-frame gap of IFG idle cycles follows every frame, and
// frames longer than MAX_FRAME_LEN are cut short (tail drained) with an oversize_err pulse.
// Build option: define ETH_TX_ARB_PRIO_EN for fixed priority (lowest index wins) instead of
// round-robin arbitration.
module eth_tx_arbiter #(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned IFG           = 12,
  parameter int unsigned MAX_FRAME_LEN = 1514,
  localparam int unsigned GrantW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  eth_tx_arbiter_if.slave   bus,
  output logic [GrantW-1:0] grant_id,
  output logic              busy,
  output logic              oversize_err
);

  localparam int unsigned CntBits = $clog2(MAX_FRAME_LEN + 1);
  localparam int unsigned CntW    = (CntBits > 11) ? CntBits : 11;
  localparam int unsigned IfgW    = (IFG > 1) ? $clog2(IFG) : 1;
  // Counter holds the remaining gap cycles minus one, so it reaches zero on the last one.
  localparam int unsigned IfgLoad = (IFG == 0) ? 0 : IFG - 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StIfg} state_e;

  state_e              state_q, state_d;
  logic [GrantW-1:0]   grant_q, grant_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [IfgW-1:0]     ifg_q, ifg_d;
  logic                oversize_q, oversize_d;
  logic [GrantW-1:0]   winner, cand;
  logic                at_max;
  logic                frame_end;
  logic                fwd_valid, fwd_last;
  logic [7:0]          fwd_data;
  logic [NUM_SRC-1:0]  ready_d;
`ifndef ETH_TX_ARB_PRIO_EN
  logic [GrantW-1:0]   last_q, last_d;
`endif

  assign at_max = (beat_q == CntW'(MAX_FRAME_LEN - 1));

  // Arbitration winner among current requesters.
  always_comb begin
    winner = '0;
    cand   = '0;
`ifdef ETH_TX_ARB_PRIO_EN
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      cand = GrantW'(i);
      if (bus.src_valid[cand]) winner = cand;
    end
`else
    // Scan from farthest to nearest so the nearest requester after last_q wins.
    for (int unsigned k = NUM_SRC; k >= 1; k--) begin
      cand = GrantW'((32'(last_q) + k) % NUM_SRC);
      if (bus.src_valid[cand]) winner = cand;
    end
`endif
  end

  // Next-state logic and the combinational datapath toward the framer.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beat_d     = beat_q;
    ifg_d      = ifg_q;
    oversize_d = 1'b0;
    frame_end  = 1'b0;
    fwd_valid  = 1'b0;
    fwd_data   = '0;
    fwd_last   = 1'b0;
    ready_d    = '0;
`ifndef ETH_TX_ARB_PRIO_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.src_valid) begin
          grant_d = winner;
          state_d = StXfer;
        end
      end
      StXfer: begin
        fwd_valid        = bus.src_valid[grant_q];
        fwd_data         = bus.src_data[{grant_q, 3'b000} +: 8];
        fwd_last         = bus.src_last[grant_q] | at_max;
        ready_d[grant_q] = bus.tx_ready;
        if (bus.src_valid[grant_q] && bus.tx_ready) begin
          beat_d = beat_q + 1'b1;
          if (bus.src_last[grant_q]) begin
            frame_end = 1'b1;
          end else if (at_max) begin
            oversize_d = 1'b1;
            state_d    = StDrain;
          end
        end
      end
      StDrain: begin
        ready_d[grant_q] = 1'b1;
        if (bus.src_valid[grant_q] && bus.src_last[grant_q]) frame_end = 1'b1;
      end
      StIfg: begin
        if (ifg_q == '0) state_d = StIdle;
        else             ifg_d   = ifg_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      beat_d = '0;
`ifndef ETH_TX_ARB_PRIO_EN
      last_d = grant_q;
`endif
      if (IFG == 0) begin
        state_d = StIdle;
      end else begin
        state_d = StIfg;
        ifg_d   = IfgW'(IfgLoad);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      beat_q     <= '0;
      ifg_q      <= '0;
      oversize_q <= 1'b0;
`ifndef ETH_TX_ARB_PRIO_EN
      last_q     <= GrantW'(NUM_SRC - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      beat_q     <= beat_d;
      ifg_q      <= ifg_d;
      oversize_q <= oversize_d;
`ifndef ETH_TX_ARB_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.tx_valid  = fwd_valid;
  assign bus.tx_data   = fwd_data;
  assign bus.tx_last   = fwd_last;
  assign bus.src_ready = ready_d;
  assign grant_id      = grant_q;
  assign busy          = (state_q != StIdle);
  assign oversize_err  = oversize_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Testbench for eth_tx_arbiter: directed frames per source, a frame-level model that
// predicts every forwarded beat, and a per-cycle compare process.
module tb_eth_tx_arbiter;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned IFG     = 12;
  localparam int unsigned MAX_LEN = 1514;

  typedef struct packed {
    logic [7:0] src;
    logic [7:0] data;
    logic       last;
    logic       trunc;
  } exp_t;

  typedef struct packed {
    int len;
    int seed;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] grant_id;
  logic       busy;
  logic       oversize_err;

  eth_tx_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  eth_tx_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .IFG          (IFG),
    .MAX_FRAME_LEN(MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .oversize_err(oversize_err)
  );

  initial forever #5 clk = ~clk;

  int      n_checks = 0;
  int      n_errors = 0;
  logic [8:0] srcq [NUM_SRC][$];   // {last, data} bytes still to be offered per source
  frame_t  mpend [NUM_SRC][$];     // frames not yet scheduled by the model
  exp_t    exp_q [$];              // predicted tx beats in order
  int      rr_ptr = NUM_SRC - 1;
  bit      gap_en = 0, bp_en = 0, chk_en = 0;
  int      ncyc = 0, cur_beats = 0, cur_start = 0;
  int      last_end = -1000, drain_end = -1000, drain_cnt = 0, ovf_cnt = 0;
  bit      draining = 0, exp_ovf = 0;
  int      obs_src [$], obs_len [$], obs_start [$], obs_end [$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] fbyte(input int seed, input int k);
    return 8'((seed * 37) + (k * 11) + (k / 256));
  endfunction

  task automatic add_frame(input int s, input int len, input int seed);
    frame_t f;
    for (int k = 0; k < len; k++) srcq[s].push_back({(k == len - 1), fbyte(seed, k)});
    f.len  = len;
    f.seed = seed;
    mpend[s].push_back(f);
  endtask

  // Schedule all pending frames: pick the next source by the arbitration rule, emit the
  // first min(len, MAX_LEN) bytes, flagging a cut frame on its final forwarded beat.
  task automatic plan();
    int     s, n;
    frame_t f;
    exp_t   e;
    while (1) begin
      s = -1;
`ifdef ETH_TX_ARB_PRIO_EN
      for (int i = 0; i < NUM_SRC && s < 0; i++) if (mpend[i].size() > 0) s = i;
`else
      for (int k = 1; k <= NUM_SRC && s < 0; k++)
        if (mpend[(rr_ptr + k) % NUM_SRC].size() > 0) s = (rr_ptr + k) % NUM_SRC;
`endif
      if (s < 0) break;
      f = mpend[s].pop_front();
      n = (f.len > int'(MAX_LEN)) ? int'(MAX_LEN) : f.len;
      for (int k = 0; k < n; k++) begin
        e.src   = 8'(s);
        e.data  = fbyte(f.seed, k);
        e.last  = (k == n - 1);
        e.trunc = (k == n - 1) && (f.len > int'(MAX_LEN));
        exp_q.push_back(e);
      end
      rr_ptr = s;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic compare_cycle();
    logic [NUM_SRC-1:0] g1h;
    logic [NUM_SRC-1:0] sfire;
    exp_t e;
    g1h = '0;
    g1h[grant_id] = 1'b1;
    sfire = bus.src_valid & bus.src_ready;
    check("oversize_pulse", oversize_err, exp_ovf);
    if (oversize_err) ovf_cnt++;
    exp_ovf = 0;
    check("ready_isolation", bus.src_ready & ~g1h, 0);
    if (ncyc > last_end && ncyc <= last_end + int'(IFG)) begin
      check("ifg_tx_valid", bus.tx_valid, 0);
      check("ifg_src_ready", bus.src_ready, 0);
      check("ifg_busy", busy, 1);
    end else if (ncyc == last_end + int'(IFG) + 1) begin
      check("arb_busy", busy, 0);
      check("arb_tx_valid", bus.tx_valid, 0);
    end
    if (draining) begin
      check("drain_tx_valid", bus.tx_valid, 0);
      check("drain_src_ready", bus.src_ready, g1h);
      if (sfire[grant_id]) begin
        drain_cnt++;
        if (bus.src_last[grant_id]) begin
          draining  = 0;
          last_end  = ncyc;
          drain_end = ncyc;
        end
      end
    end
    if (bus.tx_valid && bus.tx_ready) begin
      check("xfer_busy", busy, 1);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_src", grant_id, e.src);
        check("beat_data", bus.tx_data, e.data);
        check("beat_last", bus.tx_last, e.last);
        cur_beats++;
        if (cur_beats == 1) cur_start = ncyc;
        if (e.last) begin
          obs_src.push_back(e.src);
          obs_len.push_back(cur_beats);
          obs_start.push_back(cur_start);
          obs_end.push_back(ncyc);
          cur_beats = 0;
          if (e.trunc) begin
            draining  = 1;
            drain_cnt = 0;
            exp_ovf   = 1;
          end else begin
            last_end = ncyc;
          end
        end
      end
    end
  endtask

  // Compare process: outputs are sampled mid-cycle.
  initial begin : compare
    forever begin
      @(negedge clk);
      ncyc++;
      if (chk_en && rst_n) compare_cycle();
    end
  end

  // Source/framer driver: retire accepted bytes, then present the next ones after the edge.
  initial begin : driver
    logic [NUM_SRC-1:0] fire;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_last  = '0;
    bus.tx_ready  = 1'b1;
    forever begin
      @(negedge clk);
      fire = bus.src_valid & bus.src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        if (srcq[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
          bus.src_valid[i]         = 1'b1;
          bus.src_data[8*i +: 8]   = srcq[i][0][7:0];
          bus.src_last[i]          = srcq[i][0][8];
        end else begin
          bus.src_valid[i]         = 1'b0;
          bus.src_last[i]          = 1'b0;
        end
      end
      bus.tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (i < lim && !(exp_q.size() == 0 && !draining && busy == 1'b0 && all_empty())) begin
      @(negedge clk);
      i++;
    end
    check("idle_within_budget", (i < lim), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int b, o, lim;
    int t2_order [6];
`ifdef ETH_TX_ARB_PRIO_EN
    t2_order = '{0, 0, 0, 1, 1, 1};
`else
    t2_order = '{0, 1, 0, 1, 0, 1};
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_last", bus.tx_last, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_oversize", oversize_err, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;

    // Simultaneous continuous requests, three frames per source.
    b = obs_len.size();
    for (int r = 0; r < 3; r++) begin
      add_frame(0, 8 + r, 10 + r);
      add_frame(1, 11 + r, 20 + r);
    end
    plan();
    wait_idle(2000);
    check("t2_frame_count", obs_len.size() - b, 6);
    if (obs_len.size() >= b + 6)
      for (int i = 0; i < 6; i++) check("t2_grant_order", obs_src[b + i], t2_order[i]);

    // 60-byte frame followed by another from the same source.
    b = obs_len.size();
    add_frame(0, 60, 40);
    add_frame(0, 10, 41);
    plan();
    wait_idle(1000);
    check("t1_frame_count", obs_len.size() - b, 2);
    if (obs_len.size() >= b + 2) begin
      check("t1_len", obs_len[b], 60);
      check("t1_src", obs_src[b], 0);
      check("t1_gap", obs_start[b + 1] - obs_end[b], 14);
      check("t1_len2", obs_len[b + 1], 10);
    end

    // Oversize frame from source 1; source 0 requests while it is in flight.
    b = obs_len.size();
    o = ovf_cnt;
    add_frame(1, 1600, 50);
    plan();
    lim = 0;
    while (cur_beats == 0 && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    check("t3_start_within_budget", (lim < 100), 1);
    add_frame(0, 20, 51);
    plan();
    wait_idle(4000);
    check("t3_frame_count", obs_len.size() - b, 2);
    if (obs_len.size() >= b + 2) begin
      check("t3_src", obs_src[b], 1);
      check("t3_len", obs_len[b], 1514);
      check("t3_oversize_pulses", ovf_cnt - o, 1);
      check("t3_drained", drain_cnt, 86);
      check("t3_next_src", obs_src[b + 1], 0);
      check("t3_gap_after_drain", obs_start[b + 1] - drain_end, 14);
    end

    // Backpressure and source gaps on a 100-byte frame.
    gap_en = 1;
    bp_en  = 1;
    b = obs_len.size();
    add_frame(1, 100, 60);
    plan();
    wait_idle(3000);
    gap_en = 0;
    bp_en  = 0;
    check("t4_frame_count", obs_len.size() - b, 1);
    if (obs_len.size() >= b + 1) begin
      check("t4_len", obs_len[b], 100);
      check("t4_src", obs_src[b], 1);
    end
    repeat (2) @(negedge clk);

    // Single-byte frame, then a request from source 0 during the gap.
    b = obs_len.size();
    add_frame(1, 1, 70);
    plan();
    lim = 0;
    while (obs_len.size() == b && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    check("t6_beat_within_budget", (lim < 100), 1);
    repeat (3) @(negedge clk);
    add_frame(0, 5, 71);
    plan();
    wait_idle(500);
    check("t6_frame_count", obs_len.size() - b, 2);
    if (obs_len.size() >= b + 2) begin
      check("t6_len", obs_len[b], 1);
      check("t6_src", obs_src[b], 1);
      check("t6_next_src", obs_src[b + 1], 0);
      check("t6_next_start", obs_start[b + 1] - obs_end[b], 14);
    end

    // Reset in the middle of a frame.
    add_frame(1, 100, 80);
    plan();
    lim = 0;
    while (cur_beats < 30 && lim < 300) begin
      @(negedge clk);
      lim++;
    end
    check("t5_beats_within_budget", (lim < 300), 1);
    @(posedge clk);
    #3;
    check("t5_pre_reset_tx_valid", bus.tx_valid, 1);
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    check("t5_rst_tx_valid", bus.tx_valid, 0);
    check("t5_rst_src_ready", bus.src_ready, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_grant_id", grant_id, 0);
    for (int i = 0; i < NUM_SRC; i++) begin
      srcq[i].delete();
      mpend[i].delete();
    end
    exp_q.delete();
    rr_ptr    = NUM_SRC - 1;
    cur_beats = 0;
    draining  = 0;
    exp_ovf   = 0;
    last_end  = -1000;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1;
    b = obs_len.size();
    o = ovf_cnt;
    add_frame(1, 20, 81);
    add_frame(0, MAX_LEN, 82);
    plan();
    wait_idle(4000);
    check("t5_frame_count", obs_len.size() - b, 2);
    if (obs_len.size() >= b + 2) begin
      check("t5_first_src", obs_src[b], 0);
      check("t5_full_len", obs_len[b], 1514);
      check("t5_no_oversize", ovf_cnt - o, 0);
      check("t5_second_src", obs_src[b + 1], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
